// File: rtl/aes_pkg.sv
// aes_pkg: shared AES round-key buffer constants and buffer FSM state encoding
package aes_pkg;
   localparam int AES_NUM_ROUNDS = 10;
   localparam int AES_KEY_W      = 128;
   localparam int AES_BYTE_W     = 8;
   localparam int AES_BEATS      = AES_KEY_W / AES_BYTE_W;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_ZERO   = 2'd2;
endpackage

// File: rtl/key_byte_serializer.sv
// key_byte_serializer: loads a 128-bit key and emits it MSB-first, one byte per valid/ready handshake
module key_byte_serializer
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  abort,
   input  logic                  ready,
   input  logic [AES_KEY_W-1:0]  key,
   output logic [AES_BYTE_W-1:0] byte_out,
   output logic                  valid,
   output logic                  last
);
   localparam int CW = $clog2(AES_BEATS);
   logic [AES_KEY_W-1:0] sreg_q, sreg_d;
   logic [CW-1:0]        beat_q, beat_d;
   logic                 valid_q, valid_d;
   assign byte_out = sreg_q[AES_KEY_W-1 -: AES_BYTE_W];
   assign valid    = valid_q;
   assign last     = valid_q && beat_q == CW'(AES_BEATS - 1);
   // abort wins over load; each handshake shifts one byte out, the final one empties the stage
   always_comb begin
      sreg_d  = sreg_q;
      beat_d  = beat_q;
      valid_d = valid_q;
      if (abort) begin
         valid_d = 1'b0;
         beat_d  = '0;
      end else if (load) begin
         sreg_d  = key;
         beat_d  = '0;
         valid_d = 1'b1;
      end else if (valid_q && ready) begin
         sreg_d  = sreg_q << AES_BYTE_W;
         beat_d  = beat_q + 1'b1;
         valid_d = !last;
      end
   end
   // serializer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q  <= '0;
         beat_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sreg_q  <= sreg_d;
         beat_q  <= beat_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: rtl/round_key_buffer.sv
// round_key_buffer: 11-entry round-key store serving byte streams; KEYBUF_ZEROIZE_EN adds a flush zeroize sweep
module round_key_buffer
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   input  logic [3:0]            wr_round,
   input  logic [AES_KEY_W-1:0]  wr_key,
   output logic                  wr_err,
   input  logic                  flush,
   output logic                  all_loaded,
   input  logic                  rd_req,
   input  logic [3:0]            rd_round,
   output logic                  rd_miss,
   output logic                  busy,
   output logic [AES_BYTE_W-1:0] byte_out,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic                  byte_last
);
   localparam int DEPTH = AES_NUM_ROUNDS + 1;
   logic [AES_KEY_W-1:0] mem_q [DEPTH];
   logic [AES_KEY_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]     loaded_q, loaded_d;
   logic [1:0]           state_q, state_d;
   logic                 wr_err_q, wr_err_d, rd_miss_q, rd_miss_d, all_loaded_q, all_loaded_d;
   logic                 wr_ok, rd_hit, ser_load, ser_abort;
   logic [AES_KEY_W-1:0] rd_key;
`ifdef KEYBUF_ZEROIZE_EN
   logic [3:0]           zidx_q, zidx_d;
`endif
   assign wr_ok      = wr_valid && wr_round <= 4'(AES_NUM_ROUNDS);
   assign wr_err     = wr_err_q;
   assign rd_miss    = rd_miss_q;
   assign all_loaded = all_loaded_q;
   assign busy       = state_q != ST_IDLE;
   // entry select for reads; an out-of-range index matches nothing and so never hits
   always_comb begin
      rd_key = '0;
      rd_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_round == 4'(i)) begin
            rd_key = mem_q[i];
            rd_hit = loaded_q[i];
         end
      end
   end
   // buffer control: flush first, then zeroize sweep, then writes and stream requests
   always_comb begin
      state_d      = state_q;
      loaded_d     = loaded_q;
      mem_d        = mem_q;
      wr_err_d     = 1'b0;
      rd_miss_d    = 1'b0;
      ser_load     = 1'b0;
      ser_abort    = 1'b0;
      all_loaded_d = &loaded_q;
`ifdef KEYBUF_ZEROIZE_EN
      zidx_d       = zidx_q;
`endif
      if (flush) begin
         loaded_d  = '0;
         ser_abort = 1'b1;
`ifdef KEYBUF_ZEROIZE_EN
         state_d   = ST_ZERO;
         zidx_d    = '0;
`else
         state_d   = ST_IDLE;
`endif
      end
`ifdef KEYBUF_ZEROIZE_EN
      else if (state_q == ST_ZERO) begin
         for (int i = 0; i < DEPTH; i++)
            if (zidx_q == 4'(i)) mem_d[i] = '0;
         zidx_d  = zidx_q + 4'd1;
         state_d = zidx_q == 4'(AES_NUM_ROUNDS) ? ST_IDLE : ST_ZERO;
      end
`endif
      else begin
         wr_err_d = wr_valid && !wr_ok;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && wr_round == 4'(i)) begin
               mem_d[i]    = wr_key;
               loaded_d[i] = 1'b1;
            end
         end
         if (state_q == ST_IDLE && rd_req) begin
            ser_load  = rd_hit;
            rd_miss_d = !rd_hit;
            state_d   = rd_hit ? ST_STREAM : ST_IDLE;
         end
         if (state_q == ST_STREAM && byte_valid && byte_ready && byte_last) state_d = ST_IDLE;
      end
   end
   // key storage has no reset; its contents are only observable through the loaded mask
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
   // control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         loaded_q     <= '0;
         wr_err_q     <= 1'b0;
         rd_miss_q    <= 1'b0;
         all_loaded_q <= 1'b0;
`ifdef KEYBUF_ZEROIZE_EN
         zidx_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         loaded_q     <= loaded_d;
         wr_err_q     <= wr_err_d;
         rd_miss_q    <= rd_miss_d;
         all_loaded_q <= all_loaded_d;
`ifdef KEYBUF_ZEROIZE_EN
         zidx_q       <= zidx_d;
`endif
      end
   end
   key_byte_serializer u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ser_load),
      .abort    (ser_abort),
      .ready    (byte_ready),
      .key      (rd_key),
      .byte_out (byte_out),
      .valid    (byte_valid),
      .last     (byte_last)
   );
endmodule

// File: tb/tb_round_key_buffer.sv
// tb_round_key_buffer: vector table plus scoreboarded stream sequences for round_key_buffer
module tb_round_key_buffer;
   logic         clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, flush = 1'b0, rd_req = 1'b0, byte_ready = 1'b0;
   logic [3:0]   wr_round = '0, rd_round = '0;
   logic [127:0] wr_key = '0;
   logic         wr_err, all_loaded, rd_miss, busy, byte_valid, byte_last;
   logic [7:0]   byte_out;
   int           checks = 0, errors = 0;
   typedef struct {logic [7:0] b; logic last;} sb_t;
   typedef struct {logic wv; logic [3:0] wr; logic rq; logic [3:0] rr; logic e_err; logic e_miss; logic e_busy;} vec_t;
   sb_t          sbq[$];
   vec_t         vecs[8];
   logic [127:0] mm [11];
   logic [10:0]  ml = '0;

   always #5 clk = ~clk;

   round_key_buffer dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_round(wr_round), .wr_key(wr_key),
      .wr_err(wr_err), .flush(flush), .all_loaded(all_loaded), .rd_req(rd_req), .rd_round(rd_round),
      .rd_miss(rd_miss), .busy(busy), .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .byte_last(byte_last)
   );

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic [127:0] kpat(input int r);
      return {16{8'(r)}};
   endfunction

   function automatic bit hit(input logic [3:0] r);
      return r <= 4'd10 && ml[r];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_key(input logic [127:0] k);
      for (int i = 0; i < 16; i++) sbq.push_back('{k[127-8*i -: 8], i == 15});
   endtask

   // every accepted byte is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && byte_valid && byte_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none at %0t", byte_out, $time);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("stream_byte", byte_out, e.b);
            chk("stream_last", byte_last, e.last);
         end
      end
   end

   task automatic write_key(input int r, input logic [127:0] k);
      wr_valid = 1'b1;
      wr_round = 4'(r);
      wr_key   = k;
      step();
      wr_valid = 1'b0;
      chk("wr_err", wr_err, r > 10);
      if (r <= 10) begin
         mm[r] = k;
         ml[r] = 1'b1;
      end
   endtask

   task automatic request(input logic [3:0] r);
      bit h;
      h = hit(r);
      if (h) push_key(mm[r]);
      rd_req   = 1'b1;
      rd_round = r;
      step();
      rd_req = 1'b0;
      chk("req_miss", rd_miss, !h);
      chk("req_busy", busy, h);
      chk("req_valid", byte_valid, h);
   endtask

   // run the stream until max_hs handshakes or valid drops; alt toggles ready 1010..
   task automatic stream_run(input bit alt, input int max_hs, output int k, output int hs);
      logic [7:0] pb;
      logic       pr;
      k  = 0;
      hs = 0;
      while (byte_valid && hs < max_hs && k < 200) begin
         byte_ready = alt ? (k % 2 == 0) : 1'b1;
         pb = byte_out;
         pr = byte_ready;
         step();
         k++;
         if (pr) hs++;
         else begin
            chk("stall_valid", byte_valid, 1);
            chk("stall_hold", byte_out, pb);
         end
      end
      byte_ready = 1'b0;
      if (k >= 200) chk("stream_timeout", k, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int k, hs, n;
      logic [127:0] kb;
      vecs[0] = '{1'b1, 4'd12, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 4'd0,  1'b1, 4'd7,  1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 4'd0,  1'b1, 4'd3,  1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 4'd0,  1'b1, 4'd11, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 4'd15, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 4'd10, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 4'd0,  1'b1, 4'd10, 1'b0, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", byte_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last", byte_last, 0);
      chk("rst_byte", byte_out, 0);
      chk("rst_all_loaded", all_loaded, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_rd_miss", rd_miss, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         vec_t v;
         v = vecs[i];
         if (v.rq && !v.e_miss) push_key(mm[v.rr]);
         wr_valid = v.wv;
         wr_round = v.wr;
         wr_key   = kpat(int'(v.wr));
         rd_req   = v.rq;
         rd_round = v.rr;
         step();
         wr_valid = 1'b0;
         rd_req   = 1'b0;
         if (v.wv && v.wr <= 4'd10) begin
            mm[v.wr] = kpat(int'(v.wr));
            ml[v.wr] = 1'b1;
         end
         chk($sformatf("vec%0d_err", i), wr_err, v.e_err);
         chk($sformatf("vec%0d_miss", i), rd_miss, v.e_miss);
         chk($sformatf("vec%0d_busy", i), busy, v.e_busy);
         if (v.e_busy) begin
            stream_run(1'b0, 99, k, hs);
            chk($sformatf("vec%0d_beats", i), hs, 16);
         end
      end
      chk("vec_all_loaded", all_loaded, 0);

      for (int r = 0; r <= 10; r++) write_key(r, kpat(r));
      step();
      chk("all_loaded_full", all_loaded, 1);

      request(4'd3);
      stream_run(1'b0, 99, k, hs);
      chk("r3_valid_cycles", k, 16);
      chk("r3_beats", hs, 16);
      chk("r3_end_busy", busy, 0);
      chk("r3_end_valid", byte_valid, 0);

      step();
      request(4'd10);
      stream_run(1'b1, 99, k, hs);
      chk("bp_cycles", k, 31);
      chk("bp_beats", hs, 16);

      step();
      request(4'd2);
      stream_run(1'b0, 4, k, hs);
      chk("snap_pre_beats", hs, 4);
      kb = {$urandom, $urandom, $urandom, $urandom};
      wr_valid = 1'b1;
      wr_round = 4'd2;
      wr_key = kb;
      byte_ready = 1'b1;
      step();
      wr_valid = 1'b0;
      byte_ready = 1'b0;
      mm[2] = kb;
      stream_run(1'b0, 10, k, hs);
      chk("snap_at_last", byte_last, 1);
      rd_req = 1'b1;
      rd_round = 4'd2;
      byte_ready = 1'b1;
      step();
      rd_req = 1'b0;
      byte_ready = 1'b0;
      chk("busy_req_no_miss", rd_miss, 0);
      chk("busy_req_ignored", busy, 0);
      chk("busy_req_no_valid", byte_valid, 0);
      request(4'd2);
      stream_run(1'b0, 99, k, hs);
      chk("snap_new_beats", hs, 16);

      step();
      request(4'd5);
      stream_run(1'b0, 8, k, hs);
      flush = 1'b1;
      wr_valid = 1'b1;
      wr_round = 4'd4;
      wr_key = ~kpat(4);
      step();
      flush = 1'b0;
      wr_valid = 1'b0;
      sbq.delete();
      ml = '0;
      chk("flush_valid", byte_valid, 0);
      chk("flush_last", byte_last, 0);
      chk("flush_wr_err", wr_err, 0);
      chk("flush_rd_miss", rd_miss, 0);
`ifdef KEYBUF_ZEROIZE_EN
      n = 0;
      while (busy && n < 100) begin
         n++;
         step();
      end
      chk("zero_busy_cycles", n, 11);
`else
      chk("flush_busy", busy, 0);
      n = 0;
`endif
      step();
      chk("flush_all_loaded", all_loaded, 0);
      for (int r = 0; r <= 10; r++) if (r != 4) write_key(r, kpat(r));
      step();
      chk("reload_partial", all_loaded, 0);
      request(4'd4);
      write_key(4, kpat(4));
      step();
      chk("reload_full", all_loaded, 1);

      request(4'd0);
      stream_run(1'b0, 5, k, hs);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", byte_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_last", byte_last, 0);
      sbq.delete();
      ml = '0;
      step();
      chk("arst_all_loaded", all_loaded, 0);
      rst_n = 1'b1;
      step();
      request(4'd0);
      step();
      chk("sb_empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
